// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity and stop bits.
// Build option: UART_TX_CTRL_STOP2_EN selects two stop bits instead of one.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  par_bit,
   output logic                  par_calc_en,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic [CW-1:0]         cnt_r, cnt_s;
   logic [DATA_WIDTH-1:0] shift_r, shift_s, shift_shr_s;
   logic                  par_en_r, par_en_s;
   logic                  tx_r, tx_s;
   logic                  busy_r, busy_s;
   logic                  unused_par_typ_s;

   // Parity type is consumed by the external parity unit only.
   assign unused_par_typ_s = PAR_TYP;
   assign shift_shr_s      = shift_r >> 1'b1;
   assign par_calc_en      = Data_Valid & (state_r == ST_IDLE) & RST;
   assign TX_OUT           = tx_r;
   assign Busy             = busy_r;

   // Next-state logic; tx_s/busy_s are the line values for the cycle after this edge.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      shift_s  = shift_r;
      par_en_s = par_en_r;
      tx_s     = 1'b1;
      busy_s   = 1'b1;
      case (state_r)
         ST_IDLE: begin
            if (Data_Valid) begin
               state_s  = ST_START;
               shift_s  = P_DATA;
               par_en_s = PAR_EN;
               cnt_s    = CNT_ZERO;
               tx_s     = 1'b0;
            end else begin
               busy_s   = 1'b0;
            end
         end
         ST_START: begin
            state_s = ST_DATA;
            tx_s    = shift_r[0];
         end
         ST_DATA: begin
            cnt_s   = cnt_r + CNT_ONE;
            shift_s = shift_shr_s;
            if (cnt_r == LAST_BIT) begin
               if (par_en_r) begin
                  state_s = ST_PARITY;
                  tx_s    = par_bit;
               end else begin
                  state_s = ST_STOP;
                  cnt_s   = CNT_ZERO;
               end
            end else begin
               tx_s    = shift_shr_s[0];
            end
         end
         ST_PARITY: begin
            state_s = ST_STOP;
            cnt_s   = CNT_ZERO;
         end
         ST_STOP: begin
`ifdef UART_TX_CTRL_STOP2_EN
            // Counter marks the first stop cycle so the line stays high for a second one.
            if (cnt_r == CNT_ZERO) begin
               cnt_s   = CNT_ONE;
            end else begin
               state_s = ST_IDLE;
               busy_s  = 1'b0;
            end
`else
            state_s = ST_IDLE;
            busy_s  = 1'b0;
`endif
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State, datapath and registered line outputs with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_r  <= ST_IDLE;
         cnt_r    <= CNT_ZERO;
         shift_r  <= '0;
         par_en_r <= 1'b0;
         tx_r     <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         shift_r  <= shift_s;
         par_en_r <= par_en_s;
         tx_r     <= tx_s;
         busy_r   <= busy_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected line/busy values are queued per cycle at stimulus time.
module tb_uart_tx_ctrl;

   localparam int DW = 8;
`ifdef UART_TX_CTRL_STOP2_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          Data_Valid = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic          par_bit = 1'b0;
   logic          par_calc_en, TX_OUT, Busy;

   typedef struct {
      int   cyc;
      logic tx;
      logic busy;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .par_bit(par_bit),
      .par_calc_en(par_calc_en), .TX_OUT(TX_OUT), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Registered parity unit model: captures parity of the byte on the strobe edge.
   always @(posedge CLK) if (par_calc_en) par_bit <= (^P_DATA) ^ PAR_TYP;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge CLK) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         check("tx_out", {31'd0, TX_OUT}, {31'd0, e.tx});
         check("busy", {31'd0, Busy}, {31'd0, e.busy});
      end
   end

   function automatic int frame_len(input logic pe);
      return 1 + DW + (pe ? 1 : 0) + NSTOP;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_cycle(input int target);
      while (cyc < target) tick();
   endtask

   task automatic push_frame(input int n, input logic [DW-1:0] d, input logic pe, input logic pt);
      int k;
      k = n + 1;
      sb.push_back('{k, 1'b0, 1'b1}); k++;
      for (int i = 0; i < DW; i++) begin
         sb.push_back('{k, d[i], 1'b1}); k++;
      end
      if (pe) begin
         sb.push_back('{k, (^d) ^ pt, 1'b1}); k++;
      end
      for (int s = 0; s < NSTOP; s++) begin
         sb.push_back('{k, 1'b1, 1'b1}); k++;
      end
      sb.push_back('{k, 1'b1, 1'b0});
   endtask

   // Drive one request at the current cycle, then scramble inputs to prove they are ignored.
   task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
      P_DATA = d;
      PAR_EN = pe;
      PAR_TYP = pt;
      Data_Valid = 1'b1;
      push_frame(cyc, d, pe, pt);
      #1;
      check("pcen_accept", {31'd0, par_calc_en}, 32'd1);
      tick();
      Data_Valid = 1'b0;
      P_DATA = DW'($urandom);
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() > 0 && b < 200) begin
         tick();
         b++;
      end
      check("drain_timeout", sb.size(), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [DW-1:0] d;
      logic pe, pt;

      // Reset held with a pending request.
      RST = 1'b0;
      Data_Valid = 1'b1;
      P_DATA = 8'h55;
      PAR_EN = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("rst_tx", {31'd0, TX_OUT}, 32'd1);
         check("rst_busy", {31'd0, Busy}, 32'd0);
         check("rst_pcen", {31'd0, par_calc_en}, 32'd0);
         tick();
      end
      RST = 1'b1;
      Data_Valid = 1'b0;
      tick();
      check("post_rst_tx", {31'd0, TX_OUT}, 32'd1);
      check("post_rst_busy", {31'd0, Busy}, 32'd0);

      send(8'hA5, 1'b1, 1'b0);
      drain();
      send(8'h01, 1'b1, 1'b1);
      drain();
      send(8'h01, 1'b0, 1'b0);
      drain();

      // Request during a frame is ignored; next one accepted at the earliest cycle.
      n = cyc;
      send(8'hC3, 1'b1, 1'b0);
      wait_cycle(n + 5);
      P_DATA = 8'hFF;
      Data_Valid = 1'b1;
      #1;
      check("pcen_ignored", {31'd0, par_calc_en}, 32'd0);
      tick();
      Data_Valid = 1'b0;
      wait_cycle(n + frame_len(1'b1) + 1);
      send(8'h96, 1'b1, 1'b1);
      drain();

      // Reset in the middle of a frame abandons it.
      n = cyc;
      send(8'hE7, 1'b1, 1'b0);
      wait_cycle(n + 6);
      RST = 1'b0;
      Data_Valid = 1'b1;
      while (sb.size() > 0 && sb[sb.size()-1].cyc >= n + 7) void'(sb.pop_back());
      sb.push_back('{n + 7, 1'b1, 1'b0});
      #1;
      check("pcen_in_rst", {31'd0, par_calc_en}, 32'd0);
      tick();
      RST = 1'b1;
      Data_Valid = 1'b0;
      sb.push_back('{n + 8, 1'b1, 1'b0});
      tick();
      send(8'h3C, 1'b1, 1'b0);
      drain();

      // Back-to-back random frames at minimum spacing.
      for (int f = 0; f < 4; f++) begin
         n = cyc;
         d = DW'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         send(d, pe, pt);
         wait_cycle(n + frame_len(pe) + 1);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
